lcd_status_formatter: RTL and testbench



---
 rtl/lcd_status_formatter_if.sv | 28 ++
 rtl/lcd_status_formatter.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_status_formatter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_status_formatter_if.sv
// Bundle of the telemetry inputs and the LCD-driver handshake seen by the
// status formatter. The producer/driver side uses master, the formatter slave.
interface lcd_status_formatter_if;
    logic         sample_valid;
    logic [7:0]   temp_c;
    logic [7:0]   setpoint_c;
    logic         comp_on;
    logic         alarm;
    logic         force_refresh;
    logic         lcd_busy;
    logic [127:0] row1;
    logic [127:0] row2;
    logic         lcd_ena;
    logic         fmt_busy;
    logic         lcd_err;

    modport master (
        output sample_valid, temp_c, setpoint_c, comp_on, alarm,
               force_refresh, lcd_busy,
        input  row1, row2, lcd_ena, fmt_busy, lcd_err
    );

    modport slave (
        input  sample_valid, temp_c, setpoint_c, comp_on, alarm,
               force_refresh, lcd_busy,
        output row1, row2, lcd_ena, fmt_busy, lcd_err
    );
endinterface

// File: rtl/lcd_status_formatter.sv
// Cold-room status formatter: captures telemetry, renders two 16-char ASCII
// rows for the 16x2 LCD driver, suppresses unchanged rewrites and paces
// writes using the driver's busy flag plus a post-write hold-off.
module lcd_status_formatter #(
    parameter int unsigned HOLD_CYCLES   = 100000,
    parameter int unsigned START_TIMEOUT = 1000
) (
    input  logic                  clk_1MHz,
    input  logic                  rst,
    lcd_status_formatter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CONV_T,
        CONV_SP,
        BUILD,
        START,
        WAIT_DONE,
        HOLD
    } state_t;

    localparam logic [127:0] SPACES = {16{8'h20}};

    state_t       state;

    // Pending (most recent, not yet consumed) telemetry
    logic         pending;
    logic         pend_force;
    logic [7:0]   pend_temp;
    logic [7:0]   pend_sp;
    logic         pend_comp;
    logic         pend_alarm;

    // Working copy being converted; *_mag ends up holding the units digit
    logic [6:0]   t_mag;
    logic [6:0]   s_mag;
    logic [3:0]   t_tens;
    logic [3:0]   s_tens;
    logic         t_neg;
    logic         s_neg;
    logic         w_comp;
    logic         w_alarm;
    logic         w_force;

    logic [31:0]  cnt;
    logic [127:0] shadow1;
    logic [127:0] shadow2;
    logic [127:0] cand1;
    logic [127:0] cand2;

    logic [127:0] row1_q;
    logic [127:0] row2_q;
    logic         lcd_ena_q;
    logic         fmt_busy_q;
    logic         lcd_err_q;

    assign bus.row1     = row1_q;
    assign bus.row2     = row2_q;
    assign bus.lcd_ena  = lcd_ena_q;
    assign bus.fmt_busy = fmt_busy_q;
    assign bus.lcd_err  = lcd_err_q;

    // Magnitude of a signed byte, saturated to 99
    function automatic logic [6:0] clamp_mag(input logic [7:0] v);
        logic [7:0] a;
        a = v[7] ? (~v + 8'd1) : v;
        return (a > 8'd99) ? 7'd99 : a[6:0];
    endfunction

    // Candidate row text assembled from the converted digits and flags
    always_comb begin
        cand1 = {"TEMP:",
                 t_neg ? 8'h2D : 8'h20,
                 8'h30 + {4'h0, t_tens},
                 8'h30 + {4'h0, t_mag[3:0]},
                 "C SP:",
                 s_neg ? 8'h2D : 8'h20,
                 8'h30 + {4'h0, s_tens},
                 8'h30 + {4'h0, s_mag[3:0]}};
        cand2 = {"COMP:", w_comp ? "ON " : "OFF", " ALM:", w_alarm ? "ON " : "OFF"};
    end

    // Capture, conversion, write sequencing and registered outputs
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            pend_force <= 1'b0;
            pend_temp  <= '0;
            pend_sp    <= '0;
            pend_comp  <= 1'b0;
            pend_alarm <= 1'b0;
            t_mag      <= '0;
            s_mag      <= '0;
            t_tens     <= '0;
            s_tens     <= '0;
            t_neg      <= 1'b0;
            s_neg      <= 1'b0;
            w_comp     <= 1'b0;
            w_alarm    <= 1'b0;
            w_force    <= 1'b0;
            cnt        <= '0;
            shadow1    <= SPACES;
            shadow2    <= SPACES;
            row1_q     <= SPACES;
            row2_q     <= SPACES;
            lcd_ena_q  <= 1'b0;
            fmt_busy_q <= 1'b0;
            lcd_err_q  <= 1'b0;
        end else begin
            lcd_err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (pending) begin
                        t_mag      <= clamp_mag(pend_temp);
                        t_neg      <= pend_temp[7];
                        t_tens     <= '0;
                        s_mag      <= clamp_mag(pend_sp);
                        s_neg      <= pend_sp[7];
                        s_tens     <= '0;
                        w_comp     <= pend_comp;
                        w_alarm    <= pend_alarm;
                        w_force    <= pend_force;
                        pending    <= 1'b0;
                        pend_force <= 1'b0;
                        fmt_busy_q <= 1'b1;
                        state      <= CONV_T;
                    end
                end

                CONV_T: begin
                    if (t_mag >= 7'd10) begin
                        t_mag  <= t_mag - 7'd10;
                        t_tens <= t_tens + 4'd1;
                    end else begin
                        state <= CONV_SP;
                    end
                end

                CONV_SP: begin
                    if (s_mag >= 7'd10) begin
                        s_mag  <= s_mag - 7'd10;
                        s_tens <= s_tens + 4'd1;
                    end else begin
                        state <= BUILD;
                    end
                end

                BUILD: begin
                    if (cand1 == shadow1 && cand2 == shadow2 && !w_force) begin
                        fmt_busy_q <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        row1_q    <= cand1;
                        row2_q    <= cand2;
                        shadow1   <= cand1;
                        shadow2   <= cand2;
                        lcd_ena_q <= 1'b1;
                        cnt       <= '0;
                        state     <= START;
                    end
                end

                START: begin
                    if (bus.lcd_busy) begin
                        lcd_ena_q <= 1'b0;
                        state     <= WAIT_DONE;
                    end else if (cnt == START_TIMEOUT - 1) begin
                        lcd_ena_q  <= 1'b0;
                        lcd_err_q  <= 1'b1;
                        shadow1    <= SPACES;
                        shadow2    <= SPACES;
                        fmt_busy_q <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                WAIT_DONE: begin
                    if (!bus.lcd_busy) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end

                HOLD: begin
                    if (cnt == HOLD_CYCLES - 1) begin
                        fmt_busy_q <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                default: begin
                    lcd_ena_q  <= 1'b0;
                    fmt_busy_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase

            // Placed after the FSM so a same-cycle strobe overrides the IDLE clear
            if (bus.sample_valid) begin
                pend_temp  <= bus.temp_c;
                pend_sp    <= bus.setpoint_c;
                pend_comp  <= bus.comp_on;
                pend_alarm <= bus.alarm;
                pending    <= 1'b1;
            end
            if (bus.force_refresh) begin
                pending    <= 1'b1;
                pend_force <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_status_formatter.sv
// Testbench for lcd_status_formatter: behavioural model of the formatter's
// observable timing and text, cycle-by-cycle comparison, directed scenarios
// with literal expectations, then randomized telemetry.
module tb_lcd_status_formatter;

    localparam int HOLD = 50;
    localparam int TMO  = 20;
    localparam logic [127:0] SPACES = {16{8'h20}};
    localparam logic [127:0] R1_M18 = "TEMP:-18C SP:-20";
    localparam logic [127:0] R2_ON_OFF = "COMP:ON  ALM:OFF";
    localparam logic [127:0] R1_P05 = "TEMP: 05C SP:-20";
    localparam logic [127:0] R1_M99 = "TEMP:-99C SP:-20";
    localparam logic [127:0] R1_P03 = "TEMP: 03C SP:-20";

    logic clk_1MHz = 1'b0;
    logic rst;

    lcd_status_formatter_if bus();

    lcd_status_formatter #(
        .HOLD_CYCLES   (HOLD),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp(input logic [7:0] v);
        int x;
        x = int'($signed(v));
        if (x > 99)  x = 99;
        if (x < -99) x = -99;
        return x;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [127:0] to_vec(input string s);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
        return v;
    endfunction

    function automatic logic [127:0] text1(input logic [7:0] t, input logic [7:0] s);
        int a;
        int b;
        a = clamp(t);
        b = clamp(s);
        return to_vec($sformatf("TEMP:%c%02dC SP:%c%02d",
                                (a < 0) ? 8'h2D : 8'h20, iabs(a),
                                (b < 0) ? 8'h2D : 8'h20, iabs(b)));
    endfunction

    function automatic logic [127:0] text2(input logic c, input logic a);
        string cs;
        string as;
        cs = c ? "ON " : "OFF";
        as = a ? "ON " : "OFF";
        return to_vec($sformatf("COMP:%s ALM:%s", cs, as));
    endfunction

    logic [7:0]   m_pt, m_ps, j_t, j_s;
    logic         m_pc, m_pa, m_pend, m_pf, j_c, j_a, j_f;
    bit           m_idle, m_ena, m_wait, m_err;
    int           m_conv_left, m_age, m_hold_left;
    logic [127:0] m_row1, m_row2, m_sh1, m_sh2;

    // Model: an accepted job occupies the formatter for a conversion time derived
    // from the tens digits, then requests a write unless the text is unchanged.
    always @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            m_pt = '0; m_ps = '0; m_pc = 0; m_pa = 0; m_pend = 0; m_pf = 0;
            j_t = '0; j_s = '0; j_c = 0; j_a = 0; j_f = 0;
            m_idle = 1; m_ena = 0; m_wait = 0; m_err = 0;
            m_conv_left = 0; m_age = 0; m_hold_left = 0;
            m_row1 = SPACES; m_row2 = SPACES; m_sh1 = SPACES; m_sh2 = SPACES;
        end else begin
            m_err = 0;
            if (m_idle) begin
                if (m_pend) begin
                    j_t = m_pt; j_s = m_ps; j_c = m_pc; j_a = m_pa; j_f = m_pf;
                    m_pend = 0; m_pf = 0; m_idle = 0;
                    m_conv_left = iabs(clamp(m_pt)) / 10 + iabs(clamp(m_ps)) / 10 + 3;
                end
            end else if (m_conv_left > 0) begin
                m_conv_left--;
                if (m_conv_left == 0) begin
                    if (text1(j_t, j_s) == m_sh1 && text2(j_c, j_a) == m_sh2 && !j_f) begin
                        m_idle = 1;
                    end else begin
                        m_row1 = text1(j_t, j_s);
                        m_row2 = text2(j_c, j_a);
                        m_sh1 = m_row1;
                        m_sh2 = m_row2;
                        m_ena = 1;
                        m_age = 0;
                    end
                end
            end else if (m_ena) begin
                if (bus.lcd_busy) begin
                    m_ena = 0;
                    m_wait = 1;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin
                        m_ena = 0; m_err = 1; m_idle = 1;
                        m_sh1 = SPACES; m_sh2 = SPACES;
                    end
                end
            end else if (m_wait) begin
                if (!bus.lcd_busy) begin
                    m_wait = 0;
                    m_hold_left = HOLD;
                end
            end else if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_hold_left == 0) m_idle = 1;
            end
            if (bus.sample_valid) begin
                m_pt = bus.temp_c; m_ps = bus.setpoint_c;
                m_pc = bus.comp_on; m_pa = bus.alarm;
                m_pend = 1;
            end
            if (bus.force_refresh) begin
                m_pend = 1;
                m_pf = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk_1MHz) begin
        if (!rst) begin
            check("row1", bus.row1, m_row1);
            check("row2", bus.row2, m_row2);
            check("lcd_ena", 128'(bus.lcd_ena), 128'(m_ena));
            check("fmt_busy", 128'(bus.fmt_busy), 128'(!m_idle));
            check("lcd_err", 128'(bus.lcd_err), 128'(m_err));
        end
    end

    // Write and error event counters for the directed scenarios
    int ena_rises = 0;
    int err_cnt = 0;
    logic ena_d = 1'b0;
    always @(negedge clk_1MHz) begin
        if (bus.lcd_ena && !ena_d) ena_rises++;
        if (bus.lcd_err) err_cnt++;
        ena_d = bus.lcd_ena;
    end

    // LCD driver stand-in: answers lcd_ena with a busy pulse
    bit mute = 0;
    int long_busy = 0;
    int rph = 0, rcnt = 0, rdly = 1, rwid = 3;
    initial begin
        bus.lcd_busy = 1'b0;
        forever begin
            @(posedge clk_1MHz); #2;
            if (rst) begin
                bus.lcd_busy = 1'b0; rph = 0; rcnt = 0;
            end else if (rph == 0) begin
                if (bus.lcd_ena && !mute) begin
                    if (rcnt >= rdly) begin
                        bus.lcd_busy = 1'b1; rph = 1; rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end else begin
                    rcnt = 0;
                end
            end else begin
                rcnt++;
                if (rcnt >= rwid + long_busy) begin
                    bus.lcd_busy = 1'b0; rph = 0; rcnt = 0;
                    rdly = $urandom_range(0, 3);
                    rwid = $urandom_range(1, 6);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_1MHz); #2;
        end
    endtask

    task automatic sample(input logic [7:0] t, input logic [7:0] s, input logic c, input logic a);
        bus.temp_c = t; bus.setpoint_c = s; bus.comp_on = c; bus.alarm = a;
        bus.sample_valid = 1'b1;
        cyc(1);
        bus.sample_valid = 1'b0;
    endtask

    task automatic force_pulse();
        bus.force_refresh = 1'b1;
        cyc(1);
        bus.force_refresh = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < bound) begin
            cyc(1);
            n++;
            if (!bus.fmt_busy) quiet++;
            else quiet = 0;
        end
        tests++;
        if (quiet < 3) begin
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", bound);
        end
    endtask

    task automatic ena_latency(output int lat);
        lat = 0;
        while (!bus.lcd_ena && lat < 100) begin
            cyc(1);
            lat++;
        end
    endtask

    task automatic wait_for_busy(input int bound);
        int n;
        n = 0;
        while (!(bus.lcd_busy && !bus.lcd_ena) && n < bound) begin
            cyc(1);
            n++;
        end
        tests++;
        if (n >= bound) begin
            fails++;
            $display("FAIL wait_busy: no busy phase within %0d cycles, required one", bound);
        end
    endtask

    logic [7:0] pool [12] = '{8'h00, 8'h05, 8'hFB, 8'h63, 8'h64, 8'h9D,
                              8'h9C, 8'h7F, 8'h80, 8'h09, 8'h0A, 8'hF6};

    function automatic logic [7:0] pick();
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 11)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int lat;
        int r0;
        int e0;
        int n;

        rst = 1'b1;
        bus.sample_valid = 1'b0; bus.force_refresh = 1'b0;
        bus.temp_c = '0; bus.setpoint_c = '0; bus.comp_on = 1'b0; bus.alarm = 1'b0;
        cyc(3);
        check("reset_row1", bus.row1, SPACES);
        check("reset_row2", bus.row2, SPACES);
        check("reset_ena", 128'(bus.lcd_ena), 128'(0));
        check("reset_fmt_busy", 128'(bus.fmt_busy), 128'(0));
        check("reset_err", 128'(bus.lcd_err), 128'(0));
        rst = 1'b0;
        cyc(2);

        // First write: -18 / -20, compressor on, no alarm
        r0 = ena_rises;
        sample(8'hEE, 8'hEC, 1'b1, 1'b0);
        ena_latency(lat);
        check("latency_m18", 128'(lat), 128'(7));
        check("row1_m18", bus.row1, R1_M18);
        check("row2_m18", bus.row2, R2_ON_OFF);
        wait_idle(300);
        check("writes_first", 128'(ena_rises - r0), 128'(1));

        // Identical sample is suppressed; a forced refresh rewrites
        r0 = ena_rises;
        sample(8'hEE, 8'hEC, 1'b1, 1'b0);
        wait_idle(300);
        check("writes_dup", 128'(ena_rises - r0), 128'(0));
        r0 = ena_rises;
        force_pulse();
        wait_idle(300);
        check("writes_force", 128'(ena_rises - r0), 128'(1));
        check("row1_force", bus.row1, R1_M18);

        // Conversion length: +5 and saturated -128
        sample(8'h05, 8'hEC, 1'b1, 1'b0);
        ena_latency(lat);
        check("latency_p05", 128'(lat), 128'(6));
        check("row1_p05", bus.row1, R1_P05);
        wait_idle(300);
        sample(8'h80, 8'hEC, 1'b1, 1'b0);
        ena_latency(lat);
        check("latency_m128", 128'(lat), 128'(15));
        check("row1_m128", bus.row1, R1_M99);
        wait_idle(300);

        // Three samples during an active write collapse to one follow-up
        r0 = ena_rises;
        sample(8'h0A, 8'hEC, 1'b1, 1'b0);
        wait_for_busy(100);
        sample(8'h01, 8'hEC, 1'b1, 1'b0);
        sample(8'h02, 8'hEC, 1'b1, 1'b0);
        sample(8'h03, 8'hEC, 1'b1, 1'b0);
        wait_idle(400);
        check("writes_collapse", 128'(ena_rises - r0), 128'(2));
        check("row1_collapse", bus.row1, R1_P03);

        // Start timeout with a silent driver
        mute = 1;
        e0 = err_cnt;
        sample(8'h07, 8'hEC, 1'b1, 1'b0);
        ena_latency(lat);
        n = 0;
        while (bus.lcd_ena && n < 100) begin
            cyc(1);
            n++;
        end
        check("timeout_ena_cycles", 128'(n), 128'(TMO));
        wait_idle(300);
        check("timeout_err_pulses", 128'(err_cnt - e0), 128'(1));
        mute = 0;
        r0 = ena_rises;
        sample(8'h07, 8'hEC, 1'b1, 1'b0);
        wait_idle(300);
        check("writes_after_timeout", 128'(ena_rises - r0), 128'(1));

        // Reset while the driver is busy
        long_busy = 20;
        sample(8'h0B, 8'h05, 1'b0, 1'b1);
        wait_for_busy(100);
        rst = 1'b1;
        #1;
        check("midrst_ena", 128'(bus.lcd_ena), 128'(0));
        check("midrst_fmt_busy", 128'(bus.fmt_busy), 128'(0));
        check("midrst_row1", bus.row1, SPACES);
        check("midrst_row2", bus.row2, SPACES);
        cyc(2);
        rst = 1'b0;
        long_busy = 0;
        r0 = ena_rises;
        cyc(60);
        check("midrst_no_write", 128'(ena_rises - r0), 128'(0));

        // Randomized telemetry, refresh strobes and occasional silent driver
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mute = ($urandom_range(0, 4) == 0);
            bus.sample_valid = ($urandom_range(0, 7) == 0);
            bus.force_refresh = ($urandom_range(0, 39) == 0);
            bus.temp_c = pick();
            bus.setpoint_c = pick();
            bus.comp_on = 1'($urandom_range(0, 1));
            bus.alarm = 1'($urandom_range(0, 1));
            cyc(1);
        end
        bus.sample_valid = 1'b0;
        bus.force_refresh = 1'b0;
        mute = 0;
        wait_idle(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
